// File: rtl/bk32_cselect16_if.sv
// Operand/result bundle for the carry-select adder; the driver holds master,
// the adder holds slave.
interface bk32_cselect16_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] x1;
    logic [WIDTH-1:0] x2;
    logic             cin;
    logic [WIDTH-1:0] s;
    logic             cout;

    modport master (output x1, output x2, output cin, input s, input cout);
    modport slave  (input x1, input x2, input cin, output s, output cout);
endinterface

// File: rtl/bk32_cselect16.sv
// 32-bit adder: Brent-Kung prefix blocks in a carry-select split at SPLIT,
// registered once with asynchronous active-low reset.
module bk32_cselect16 #(
    parameter int WIDTH = 32,
    parameter int SPLIT = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    bk32_cselect16_if.slave    bus
);
    localparam int LG = $clog2(SPLIT);

    // Returns {carry_out, sum}; cin is folded into the bit-0 generate so the
    // prefix G of bit i is directly the carry into bit i+1.
    function automatic logic [SPLIT:0] bk_add(
        input logic [SPLIT-1:0] a,
        input logic [SPLIT-1:0] b,
        input logic             ci
    );
        logic [SPLIT-1:0] p;
        logic [SPLIT-1:0] gg;
        logic [SPLIT-1:0] pp;
        logic [SPLIT-1:0] c;
        p     = a ^ b;
        gg    = a & b;
        pp    = p;
        gg[0] = gg[0] | (p[0] & ci);
        for (int d = 0; d < LG; d++) begin
            for (int i = 0; i < SPLIT; i++) begin
                if (((i + 1) % (1 << (d + 1))) == 0) begin
                    gg[i] = gg[i] | (pp[i] & gg[i - (1 << d)]);
                    pp[i] = pp[i] & pp[i - (1 << d)];
                end
            end
        end
        // Down-sweep fills in the prefixes the up-sweep skipped.
        for (int d = LG - 2; d >= 0; d--) begin
            for (int i = 0; i < SPLIT; i++) begin
                if ((((i + 1) % (1 << (d + 1))) == (1 << d)) && (i >= (1 << (d + 1)))) begin
                    gg[i] = gg[i] | (pp[i] & gg[i - (1 << d)]);
                    pp[i] = pp[i] & pp[i - (1 << d)];
                end
            end
        end
        c = {gg[SPLIT-2:0], ci};
        return {gg[SPLIT-1], p ^ c};
    endfunction

    logic [SPLIT:0]       w_lo;
    logic [WIDTH-SPLIT:0] w_hi0;
    logic [WIDTH-SPLIT:0] w_hi1;
    logic [WIDTH-SPLIT:0] w_hi_sel;
    logic [WIDTH-1:0]     r_s;
    logic                 r_cout;

    assign w_lo     = bk_add(bus.x1[SPLIT-1:0], bus.x2[SPLIT-1:0], bus.cin);
    assign w_hi0    = bk_add(bus.x1[WIDTH-1:SPLIT], bus.x2[WIDTH-1:SPLIT], 1'b0);
    assign w_hi1    = bk_add(bus.x1[WIDTH-1:SPLIT], bus.x2[WIDTH-1:SPLIT], 1'b1);
    assign w_hi_sel = w_lo[SPLIT] ? w_hi1 : w_hi0;

    // Result register; reset clears it without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s    <= {WIDTH{1'b0}};
            r_cout <= 1'b0;
        end else begin
            r_s    <= {w_hi_sel[WIDTH-SPLIT-1:0], w_lo[SPLIT-1:0]};
            r_cout <= w_hi_sel[WIDTH-SPLIT];
        end
    end

    assign bus.s    = r_s;
    assign bus.cout = r_cout;
endmodule

// File: tb/tb_bk32_cselect16.sv
// Self-checking bench: 33-bit arithmetic reference model compared every
// cycle, plus directed vectors with literal expectations.
module tb_bk32_cselect16;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    logic cmp_en;
    logic [32:0] m_val;

    bk32_cselect16_if #(.WIDTH(32)) bus ();

    bk32_cselect16 #(.WIDTH(32), .SPLIT(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: exact 33-bit sum of the operands seen at each rising edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_val <= 33'd0;
        else        m_val <= {1'b0, bus.x1} + {1'b0, bus.x2} + {32'd0, bus.cin};
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            checks++;
            if ({bus.cout, bus.s} !== m_val) begin
                failures++;
                $display("FAIL model_cmp t=%0t got cout=%0b s=%h want cout=%0b s=%h",
                         $time, bus.cout, bus.s, m_val[32], m_val[31:0]);
            end
        end
    end

    task automatic chk(input string name, input logic [32:0] got, input logic [32:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got cout=%0b s=%h want cout=%0b s=%h",
                     name, got[32], got[31:0], want[32], want[31:0]);
        end
    endtask

    task automatic vec(input string name, input logic [31:0] a, input logic [31:0] b,
                       input logic c, input logic [32:0] want);
        bus.x1  = a;
        bus.x2  = b;
        bus.cin = c;
        @(posedge clk);
        #1;
        chk(name, {bus.cout, bus.s}, want);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        cmp_en   = 1'b0;
        rst_n    = 1'b0;
        bus.x1   = 32'h1234_5678;
        bus.x2   = 32'h1111_1111;
        bus.cin  = 1'b1;
        #2;
        chk("reset_async", {bus.cout, bus.s}, 33'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_hold", {bus.cout, bus.s}, 33'd0);
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        @(posedge clk);
        #1;
        chk("first_capture", {bus.cout, bus.s}, {1'b0, 32'h2345_6789} + 33'd1);

        vec("neg_add",      32'd10000,     32'hFFFF_FF9C, 1'b1, {1'b1, 32'd9901});
        vec("wrap_cin1",    32'hFFFF_FFFF, 32'h0,         1'b1, {1'b1, 32'h0});
        vec("ones_cin0",    32'hFFFF_FFFF, 32'h0,         1'b0, {1'b0, 32'hFFFF_FFFF});
        vec("c16_select",   32'h0000_FFFF, 32'h1,         1'b0, {1'b0, 32'h0001_0000});
        vec("signed_ovf",   32'h7FFF_FFFF, 32'h1,         1'b0, {1'b0, 32'h8000_0000});
        vec("msb_carry",    32'h8000_0000, 32'h8000_0000, 1'b0, {1'b1, 32'h0});
        vec("c16_via_cin",  32'h0000_FFFF, 32'h0,         1'b1, {1'b0, 32'h0001_0000});
        vec("full_ripple",  32'hFFFF_FFFF, 32'h1,         1'b0, {1'b1, 32'h0});
        vec("no_carry",     32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b0, {1'b0, 32'hFFFF_FFFF});
        vec("zero",         32'h0,         32'h0,         1'b0, {1'b0, 32'h0});

        // Mid-operation reset between edges.
        bus.x1  = 32'hDEAD_BEEF;
        bus.x2  = 32'h1000_0000;
        bus.cin = 1'b0;
        @(posedge clk);
        #3;
        cmp_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("reset_mid", {bus.cout, bus.s}, 33'd0);
        @(posedge clk);
        #1;
        chk("reset_mid_hold", {bus.cout, bus.s}, 33'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset_release_hold", {bus.cout, bus.s}, 33'd0);
        @(posedge clk);
        #1;
        chk("reset_recapture", {bus.cout, bus.s}, {1'b0, 32'hEEAD_BEEF});
        cmp_en = 1'b1;

        // Back-to-back random operands, one per cycle.
        for (int k = 0; k < 10000; k++) begin
            bus.x1  = $urandom;
            bus.x2  = $urandom;
            bus.cin = 1'($urandom_range(1, 0));
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
